jpeg_dequantizer: RTL and testbench
===================================

Name: jpeg_dequantizer

Overview:
- Decoder-side counterpart of the encoder quantizer: multiplies each quantized DCT coefficient by its quantization-table entry to reconstruct the IDCT input.
- Sits between the entropy decoder (coefficients arrive in raster order, 64 per 8x8 block) and the IDCT.
- Keeps a per-block coefficient counter (`qnt_cnt`) that indexes a 64-entry writable quantization table.
- Uses a 2-stage valid/ready pipeline.

Parameters:
- IN_W, 12, signed quantized-coefficient width
- QT_W, 8, unsigned quantization-table entry width
- OUT_W, 16, signed dequantized-output width (saturated)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cnt_clr  in  1  synchronous restart of coefficient counter (block resync)
- qt_wr  in  1  table write strobe
- qt_addr  in  6  table write address (raster index)
- qt_data  in  QT_W  table write data
- in_valid  in  1  coefficient valid
- in_ready  out  1  coefficient accepted when in_valid & in_ready
- in_data  in  IN_W  signed quantized coefficient
- out_valid  out  1  dequantized coefficient valid
- out_ready  in  1  downstream ready
- out_data  out  OUT_W  signed dequantized coefficient
- out_idx  out  6  raster index of out_data
- out_last  out  1  high when out_idx==63

Behaviour:
- Reset (asynchronous, rst=1):
  - qnt_cnt=0; both stage valids=0; out_valid=0, out_data=0, out_idx=0, out_last=0.
  - in_ready=1 after reset deasserts.
  - Table contents are not reset; power-up value is undefined and must be loaded before use.
- Reset mid-operation: in-flight data is discarded; no partial output is ever presented.
- Acceptance: occurs when in_valid & in_ready.
  - The accepted coefficient is tagged with idx=qnt_cnt and reads qt[qnt_cnt] in the same cycle.
  - qnt_cnt then increments mod 64 (63 -> 0 wrap).
- cnt_clr:
  - Sets the index used this cycle to 0, and qnt_cnt becomes (accept ? 1 : 0).
  - Data already in the pipeline keeps its tags.
- Table write: qt[qt_addr] <= qt_data at the clock edge.
  - A write to the same address as an acceptance in the same cycle is read-before-write: the coefficient uses the old entry.
- Stage 1 (registered):
  - Stores product = in_data (signed) * {0,qt_entry} (unsigned), full IN_W+QT_W+1 = 21 bits signed, plus idx.
  - A table entry of 0 yields a product of 0; no special case.
- Stage 2 (output register):
  - out_data = product saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_idx carried from stage 1; out_last = (idx==63).
- Latency: 2 cycles from acceptance to out_valid when no stall.
- Flow control:
  - Stage 2 loads when !out_valid | out_ready.
  - Stage 1 advances when !s1_valid | stage 2 loads.
  - in_ready = !s1_valid | stage 2 loads (combinational from out_ready).
- Throughput: 1 coefficient/cycle when out_ready is held high.
- out_data, out_idx and out_last hold stable while out_valid & !out_ready.
- Ordering: outputs appear in strict acceptance order; no drops or duplicates.

Decomposition:
- Shared package `jpeg_dec_pkg`:
  - constants BLK_COEFFS=64 and IDX_W=6
  - typedef coef_idx_t (6-bit)
  - saturating-resize function sat_s(value, width)
- Sub-module `jpeg_qtable_ram`: 64xQT_W, one write port and one asynchronous read port, read-before-write semantics.
- Counter, multiply and pipeline control live in the top module.

Test Plan:
- Load qt[i]=i+1 for all 64 entries; stream in_data=2 for 64 beats with out_ready=1 -> out_data=2*(i+1), out_idx=0..63, out_last only on beat 63, outputs start 2 cycles after the first acceptance.
- qt[5]=255, coefficient idx 5 with in_data=-2048 -> out_data=-522240 saturated to -32768; in_data=2047 -> 32767 (clipped from 521985).
- Hold out_ready=0 for 5 cycles with a continuous input stream -> in_ready drops after 2 accepted beats, held outputs stay stable, and no data is lost or duplicated after release.
- Write qt[0]=9 in the same cycle a coefficient with idx 0 (old qt[0]=3, in_data=4) is accepted -> out_data=12; the next block's idx 0 uses 9.
- Accept 10 coefficients, assert cnt_clr together with the 11th -> the 11th has out_idx=0, the next has out_idx=1.
- Assert rst while 2 coefficients are in flight -> out_valid=0 immediately (asynchronous); after release the next accepted coefficient has out_idx=0.

Source files
------------

// File: rtl/jpeg_dec_pkg.sv
// Shared definitions for the JPEG decoder dequantizer path.
//   BLK_COEFFS / IDX_W : coefficients per 8x8 block and raster-index width
//   coef_idx_t         : raster index (0..63) within a block
//   sat_s()            : clamp a signed value into a signed field of 'width' bits
package jpeg_dec_pkg;

    localparam int BLK_COEFFS = 64;
    localparam int IDX_W      = 6;

    typedef logic [IDX_W-1:0] coef_idx_t;

    // Returns the clamped value sign-extended to 32 bits; callers truncate
    // to the target width, which is lossless after the clamp.
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] value,
                                                 input int width);
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
        min_v = -max_v - 32'sd1;
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/jpeg_dequantizer_if.sv
// Bus bundle for the dequantizer: coefficient stream in, dequantized stream
// out, quantization-table write port and the block-resync strobe.
//   slave  : the dequantizer side
//   master : the entropy-decoder / IDCT / table-loader side
interface jpeg_dequantizer_if #(
    parameter int IN_W  = 12,
    parameter int QT_W  = 8,
    parameter int OUT_W = 16
);
    import jpeg_dec_pkg::*;

    logic                    cnt_clr;
    logic                    qt_wr;
    coef_idx_t               qt_addr;
    logic [QT_W-1:0]         qt_data;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    coef_idx_t               out_idx;
    logic                    out_last;

    modport slave (
        input  cnt_clr, qt_wr, qt_addr, qt_data, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

    modport master (
        output cnt_clr, qt_wr, qt_addr, qt_data, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/jpeg_qtable_ram.sv
// 64-entry quantization table: one synchronous write port, one asynchronous
// read port. A read and a write to the same address in one cycle return the
// old contents (the write only lands at the clock edge).
//   clk              : write clock
//   wr_en/addr/data  : table write
//   rd_addr/rd_data  : combinational read
// Contents are intentionally not reset; the table is loaded before use.
module jpeg_qtable_ram
    import jpeg_dec_pkg::*;
#(
    parameter int QT_W = 8
) (
    input  logic            clk,
    input  logic            wr_en,
    input  coef_idx_t       wr_addr,
    input  logic [QT_W-1:0] wr_data,
    input  coef_idx_t       rd_addr,
    output logic [QT_W-1:0] rd_data
);

    logic [QT_W-1:0] mem_q [BLK_COEFFS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/jpeg_dequantizer.sv
// JPEG dequantizer: multiplies each quantized coefficient by the table entry
// at its raster position and saturates the product to OUT_W bits.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : coefficient in/out streams, table write port, cnt_clr resync
// Pipeline: stage 1 holds the full-width product and index, stage 2 is the
// saturated output register. 2-cycle latency, 1 coefficient/cycle.
module jpeg_dequantizer
    import jpeg_dec_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int QT_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    jpeg_dequantizer_if.slave  bus
);

    localparam int PROD_W = IN_W + QT_W + 1;

    coef_idx_t               qnt_cnt_q, qnt_cnt_d;
    coef_idx_t               cur_idx;
    logic                    s1_valid_q, s1_valid_d;
    logic signed [PROD_W-1:0] s1_prod_q, s1_prod_d;
    coef_idx_t               s1_idx_q, s1_idx_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    coef_idx_t               out_idx_q, out_idx_d;
    logic                    out_last_q, out_last_d;

    logic [QT_W-1:0]         qt_rd;
    logic signed [PROD_W-1:0] coef_ext, qt_ext;
    logic                    s2_load, s1_adv, accept;

    // Table is read at the index of the coefficient being accepted.
    jpeg_qtable_ram #(.QT_W(QT_W)) u_qtable (
        .clk     (clk),
        .wr_en   (bus.qt_wr),
        .wr_addr (bus.qt_addr),
        .wr_data (bus.qt_data),
        .rd_addr (cur_idx),
        .rd_data (qt_rd)
    );

    always_comb begin
        s2_load = !out_valid_q || bus.out_ready;
        s1_adv  = !s1_valid_q || s2_load;
        accept  = bus.in_valid && s1_adv;

        // cnt_clr retags the current beat as the start of a block.
        cur_idx   = bus.cnt_clr ? '0 : qnt_cnt_q;
        qnt_cnt_d = accept ? cur_idx + coef_idx_t'(1) : cur_idx;

        // Signed coefficient times unsigned entry, done as a signed multiply
        // with the entry zero-extended; PROD_W holds the full result.
        coef_ext = PROD_W'(bus.in_data);
        qt_ext   = {{(PROD_W-QT_W){1'b0}}, qt_rd};

        s1_valid_d = s1_valid_q;
        s1_prod_d  = s1_prod_q;
        s1_idx_d   = s1_idx_q;
        if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_prod_d = coef_ext * qt_ext;
                s1_idx_d  = cur_idx;
            end
        end

        // Output payload only moves when a new beat loads, so it holds
        // under backpressure.
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = OUT_W'(sat_s(32'(s1_prod_q), OUT_W));
                out_idx_d  = s1_idx_q;
                out_last_d = (s1_idx_q == coef_idx_t'(BLK_COEFFS - 1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qnt_cnt_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_prod_q   <= '0;
            s1_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            qnt_cnt_q   <= qnt_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_prod_q   <= s1_prod_d;
            s1_idx_q    <= s1_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_jpeg_dequantizer.sv
// Directed bench for jpeg_dequantizer. Inputs are driven just after the
// falling edge and outputs sampled 1 time unit later; expected outputs are
// hand-computed and queued in acceptance order.
module tb_jpeg_dequantizer;

    logic clk;
    logic rst;

    jpeg_dequantizer_if #(.IN_W(12), .QT_W(8), .OUT_W(16)) bus ();

    jpeg_dequantizer #(.IN_W(12), .QT_W(8), .OUT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int data;
        int idx;
        int last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   acc;
    int   cd[12] = '{9, 2, 3, 4, 5, 255, 7, 8, 9, 10, 9, 2};
    int   ci[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push(input int d, input int i, input int l);
        exp_t e;
        e.data = d;
        e.idx  = i;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // One cycle: drive inputs at the falling edge, then score any output
    // that the coming rising edge will consume.
    task automatic step(input int v, input int d, input int clr, input int ordy,
                        input int wr, input int addr, input int wdata);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = v[0];
        bus.in_data   = 12'(d);
        bus.cnt_clr   = clr[0];
        bus.out_ready = ordy[0];
        bus.qt_wr     = wr[0];
        bus.qt_addr   = 6'(addr);
        bus.qt_data   = 8'(wdata);
        #1;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", bus.out_data, e.data);
                chk("out_idx",  bus.out_idx,  e.idx);
                chk("out_last", bus.out_last, e.last);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.cnt_clr   = 1'b0;
        bus.out_ready = 1'b1;
        bus.qt_wr     = 1'b0;
        bus.qt_addr   = '0;
        bus.qt_data   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_out_idx",   bus.out_idx,   0);
        chk("rst_out_last",  bus.out_last,  0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", bus.in_ready, 1);

        // Load qt[i] = i+1
        for (int i = 0; i < 64; i++) step(0, 0, 0, 1, 1, i, i + 1);

        // Full block of in_data=2: out = 2*(i+1), last only at 63
        for (int i = 0; i < 64; i++) push(2 * (i + 1), i, (i == 63) ? 1 : 0);
        for (int t = 0; t < 66; t++) begin
            step((t < 64) ? 1 : 0, 2, 0, 1, 0, 0, 0);
            if (t < 3) chk("first_out_latency", bus.out_valid, (t >= 2) ? 1 : 0);
        end
        idle(3);
        chk("stream_drained", exp_q.size(), 0);

        // Saturation at idx 5 with qt[5]=255
        step(0, 0, 0, 1, 1, 5, 255);
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < 6; k++) begin
                push((k < 5) ? 0 : ((g == 0) ? -32768 : 32767), k, 0);
                step(1, (k < 5) ? 0 : ((g == 0) ? -2048 : 2047), (k == 0) ? 1 : 0,
                     1, 0, 0, 0);
            end
        end
        idle(3);
        chk("sat_drained", exp_q.size(), 0);

        // Backpressure: out_ready low for 5 cycles, continuous input
        push(1, 0, 0);  push(4, 1, 0);  push(9, 2, 0);    push(16, 3, 0);
        push(25, 4, 0); push(1530, 5, 0); push(49, 6, 0); push(64, 7, 0);
        acc = 0;
        for (int t = 0; t < 40; t++) begin
            if (acc < 8) step(1, acc + 1, (acc == 0) ? 1 : 0, (t >= 5) ? 1 : 0, 0, 0, 0);
            else         step(0, 0, 0, 1, 0, 0, 0);
            if (t == 2) chk("accepted_before_stall", acc, 2);
            if (t >= 2 && t <= 4) begin
                chk("stall_in_ready",  bus.in_ready,  0);
                chk("stall_out_valid", bus.out_valid, 1);
                chk("stall_hold_data", bus.out_data,  1);
                chk("stall_hold_idx",  bus.out_idx,   0);
            end
            if (bus.in_valid && bus.in_ready) acc++;
        end
        chk("stall_all_accepted", acc, 8);
        chk("stall_drained", exp_q.size(), 0);

        // Table write colliding with a read of the same entry
        step(0, 0, 0, 1, 1, 0, 3);
        push(12, 0, 0);
        step(1, 4, 1, 1, 1, 0, 9);
        push(36, 0, 0);
        step(1, 4, 1, 1, 0, 0, 0);
        idle(3);
        chk("rbw_drained", exp_q.size(), 0);

        // cnt_clr with the 11th coefficient
        for (int k = 0; k < 12; k++) begin
            push(cd[k], ci[k], 0);
            step(1, 1, (k == 0 || k == 10) ? 1 : 0, 1, 0, 0, 0);
        end
        idle(3);
        chk("clr_drained", exp_q.size(), 0);

        // Reset with two coefficients in flight
        step(1, 1, 0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("pre_reset_out_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_out_data",  bus.out_data,  0);
        @(negedge clk);
        rst = 1'b0;
        push(9, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0);
        idle(3);
        chk("post_reset_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
